channel_emulator_ctrl_regs: RTL
===============================

Name: channel_emulator_ctrl_regs

Overview:
AXI4-Lite slave register bank providing the S00_AXI control port of the channel emulator. It is the responder side of the master VIP traffic.
- Accepts single-beat AXI4-Lite writes and reads.
- Holds the emulator's runtime configuration registers and exposes them as flat output buses to the datapath.
- Returns status and generates one-cycle control pulses.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 5, byte-address width; decodes 8 word slots.
NUM_REGS, 4, number of read/write config registers, at byte offsets 0x00 to 0x0C.

Ports:
ACLK  in  1  clock
ARESET  in  1  asynchronous active-high reset
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address
S_AXI_AWPROT  in  3  ignored
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write-address handshake
S_AXI_WDATA  in  32  write data
S_AXI_WSTRB  in  4  byte enables
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write-data handshake
S_AXI_BRESP  out  2  write response
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write-response handshake
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address
S_AXI_ARPROT  in  3  ignored
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read-address handshake
S_AXI_RDATA  out  32  read data
S_AXI_RRESP  out  2  read response
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read-data handshake
cfg_regs  out  NUM_REGS*32  config register contents; reg i occupies bits [32i+31:32i]
cfg_wr_stb  out  NUM_REGS  one-cycle pulse when reg i is written
status_in  in  32  live status word from the datapath
ctrl_pulse  out  32  one-cycle pulse of the bits written to CTRL

Behaviour:
Address map (word index = ADDR[4:2]; ADDR[1:0] ignored):
- 0 to NUM_REGS-1: RW config registers.
- 0x10: STATUS, read-only. Returns status_in sampled at AR acceptance. Writes are dropped with OKAY.
- 0x14: CTRL, write-only. Reads return 0.
- Any other index is unmapped.

Reset (ARESET high, asynchronous):
- All registers, cfg_wr_stb, ctrl_pulse, BVALID and RVALID go to 0. BRESP and RRESP go to 0.
- All READY outputs are forced low while ARESET is high.
- Any in-flight transaction is discarded with no response.

Write channel:
- AW and W each have a one-entry holding buffer.
- AWREADY = !aw_held && !BVALID && !ARESET.
- WREADY = !w_held && !BVALID && !ARESET.
- AW and W may arrive in either order or in the same cycle.
- At the first edge where both are held (including the acceptance edge itself):
  - The write commits and both buffers clear.
  - BVALID=1 and BRESP=OKAY.
  - Each byte k of the target register updates only where WSTRB[k]=1.
  - cfg_wr_stb[i] pulses for exactly 1 cycle, even when WSTRB=0.
  - Writes to CTRL drive ctrl_pulse = WDATA & byte-mask for 1 cycle. CTRL has no storage.
- BVALID holds until BREADY. No new AW or W is accepted while BVALID=1.
- Latency: AW+W accepted at edge N puts BVALID high after edge N.

Read channel:
- ARREADY = !RVALID && !ARESET.
- On an AR handshake at edge N: RDATA and RRESP are registered and RVALID=1 after edge N, i.e. 1-cycle latency.
- RDATA and RVALID hold stable until RREADY.
- RVALID back-to-back throughput is one read every 2 cycles.

Simultaneous events:
- A read and a write to the same register at the same edge: the read returns the pre-write value.
- Read and write channels are fully independent and never stall each other.

Optional Feature:
Macro CHANNEL_EMU_REG_SLVERR_EN.
- Defined: unmapped writes return BRESP=SLVERR (2'b10) and change no state. Unmapped reads return RRESP=SLVERR with RDATA=0.
- Undefined: unmapped accesses return OKAY, writes are dropped, and reads return 0.

Test Plan:
- Write 0x1, 0x2, 0x3, 0x4 to addresses 0x0, 0x4, 0x8, 0xC, then read back the same addresses -> RDATA 0x1 to 0x4, all responses OKAY; cfg_regs = 0x00000004_00000003_00000002_00000001.
- Reg0 = 0xFFFFFFFF, then write 0x12345678 with WSTRB=4'b0101 -> readback 0xFF34FF78; cfg_wr_stb[0] pulses once.
- Present W three cycles before AW, then hold BREADY low for 5 cycles -> a single commit; BVALID stays high for all 5 cycles; AWREADY and WREADY stay 0 until B completes.
- status_in=0xA5A5_0001, read 0x10; then write 0x0000_0003 to 0x14 -> RDATA 0xA5A50001; ctrl_pulse=0x3 for exactly 1 cycle; a following read of 0x14 returns 0.
- Read 0x18 with the macro defined and then undefined -> RRESP 2'b10 / 2'b00 respectively, RDATA 0 in both cases.
- Assert ARESET while RVALID=1 and an AW is held -> RVALID drops immediately, cfg_regs=0, no BVALID after release; the next write/read pair completes normally.

Source files
------------

// File: rtl/channel_emulator_ctrl_regs.sv
// channel_emulator_ctrl_regs
// AXI4-Lite slave register bank for the channel emulator S00_AXI control port.
// Word map (ADDR[4:2]): 0..NUM_REGS-1 RW config, 4 STATUS (RO), 5 CTRL (WO pulse),
// everything else unmapped.
// Optional build macro: CHANNEL_EMU_REG_SLVERR_EN -- when defined, unmapped
// accesses answer SLVERR instead of OKAY.
// NUM_REGS must not exceed 4 so the config block stays below STATUS.

module channel_emulator_ctrl_regs #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int NUM_REGS           = 4
) (
    input  logic                               ACLK,
    input  logic                               ARESET,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
    input  logic [2:0]                         S_AXI_AWPROT,
    input  logic                               S_AXI_AWVALID,
    output logic                               S_AXI_AWREADY,

    input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
    input  logic                               S_AXI_WVALID,
    output logic                               S_AXI_WREADY,

    output logic [1:0]                         S_AXI_BRESP,
    output logic                               S_AXI_BVALID,
    input  logic                               S_AXI_BREADY,

    input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
    input  logic [2:0]                         S_AXI_ARPROT,
    input  logic                               S_AXI_ARVALID,
    output logic                               S_AXI_ARREADY,

    output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
    output logic [1:0]                         S_AXI_RRESP,
    output logic                               S_AXI_RVALID,
    input  logic                               S_AXI_RREADY,

    output logic [NUM_REGS*C_S_AXI_DATA_WIDTH-1:0] cfg_regs,
    output logic [NUM_REGS-1:0]                cfg_wr_stb,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]      status_in,
    output logic [C_S_AXI_DATA_WIDTH-1:0]      ctrl_pulse
);

    localparam int         DW          = C_S_AXI_DATA_WIDTH;
    localparam int         SW          = C_S_AXI_DATA_WIDTH / 8;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] IDX_STATUS  = 3'd4;
    localparam logic [2:0] IDX_CTRL    = 3'd5;

    logic [DW-1:0]       cfg_q [NUM_REGS];
    logic [DW-1:0]       cfg_d [NUM_REGS];

    logic                aw_held_q;
    logic [2:0]          aw_idx_q;
    logic                w_held_q;
    logic [DW-1:0]       w_data_q;
    logic [SW-1:0]       w_strb_q;

    logic                bvalid_q;
    logic [1:0]          bresp_q;
    logic [NUM_REGS-1:0] wr_stb_q;
    logic [NUM_REGS-1:0] wr_stb_d;
    logic [DW-1:0]       ctrl_pulse_q;
    logic [DW-1:0]       ctrl_pulse_d;

    logic                rvalid_q;
    logic [DW-1:0]       rdata_q;
    logic [DW-1:0]       rdata_d;
    logic [1:0]          rresp_q;
    logic [1:0]          rresp_d;

    logic                aw_hs;
    logic                w_hs;
    logic                ar_hs;
    logic                commit;
    logic [2:0]          wr_idx;
    logic [DW-1:0]       wr_data;
    logic [SW-1:0]       wr_strb;
    logic [DW-1:0]       wr_mask;
    logic                wr_is_cfg;
    logic                wr_unmapped;
    logic [1:0]          bresp_d;
    logic [2:0]          rd_idx;
    logic                rd_is_cfg;

    // Protection bits and the byte lane of the address carry no meaning here.
    logic unused_inputs;
    assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                             S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

    assign S_AXI_AWREADY = !aw_held_q && !bvalid_q && !ARESET;
    assign S_AXI_WREADY  = !w_held_q  && !bvalid_q && !ARESET;
    assign S_AXI_ARREADY = !rvalid_q  && !ARESET;

    assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
    assign w_hs  = S_AXI_WVALID  && S_AXI_WREADY;
    assign ar_hs = S_AXI_ARVALID && S_AXI_ARREADY;

    // A channel counts as present either from its buffer or from this cycle's
    // handshake, so a same-cycle or second-arriving beat commits on its own edge.
    assign wr_idx  = aw_held_q ? aw_idx_q : S_AXI_AWADDR[4:2];
    assign wr_data = w_held_q  ? w_data_q : S_AXI_WDATA;
    assign wr_strb = w_held_q  ? w_strb_q : S_AXI_WSTRB;
    assign commit  = (aw_held_q || aw_hs) && (w_held_q || w_hs);

    assign wr_is_cfg   = int'(wr_idx) < NUM_REGS;
    assign wr_unmapped = !wr_is_cfg && (wr_idx != IDX_STATUS) && (wr_idx != IDX_CTRL);

    // Expand byte strobes to a bit mask and build the write-side next state.
    always_comb begin
        for (int k = 0; k < SW; k++) begin
            wr_mask[8*k +: 8] = {8{wr_strb[k]}};
        end
        for (int i = 0; i < NUM_REGS; i++) begin
            cfg_d[i]    = cfg_q[i];
            wr_stb_d[i] = 1'b0;
            if (commit && (wr_idx == 3'(i))) begin
                cfg_d[i]    = (cfg_q[i] & ~wr_mask) | (wr_data & wr_mask);
                wr_stb_d[i] = 1'b1;
            end
        end
        ctrl_pulse_d = '0;
        if (commit && (wr_idx == IDX_CTRL)) begin
            ctrl_pulse_d = wr_data & wr_mask;
        end
`ifdef CHANNEL_EMU_REG_SLVERR_EN
        bresp_d = wr_unmapped ? RESP_SLVERR : RESP_OKAY;
`else
        bresp_d = RESP_OKAY;
`endif
    end

    // AW/W holding buffers, write response and the one-cycle strobes.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            aw_held_q    <= 1'b0;
            aw_idx_q     <= '0;
            w_held_q     <= 1'b0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            bvalid_q     <= 1'b0;
            bresp_q      <= RESP_OKAY;
            wr_stb_q     <= '0;
            ctrl_pulse_q <= '0;
        end else begin
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= S_AXI_AWADDR[4:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= S_AXI_WDATA;
                    w_strb_q <= S_AXI_WSTRB;
                end
            end
            if (commit) begin
                bvalid_q <= 1'b1;
                bresp_q  <= bresp_d;
            end else if (S_AXI_BREADY) begin
                bvalid_q <= 1'b0;
            end
            wr_stb_q     <= wr_stb_d;
            ctrl_pulse_q <= ctrl_pulse_d;
        end
    end

    // Configuration storage.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cfg_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                cfg_q[i] <= cfg_d[i];
            end
        end
    end

    assign rd_idx    = S_AXI_ARADDR[4:2];
    assign rd_is_cfg = int'(rd_idx) < NUM_REGS;

    // Read decode; uses pre-write cfg_q so a colliding write is not visible yet.
    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (rd_idx == 3'(i)) begin
                rdata_d = cfg_q[i];
            end
        end
        if (rd_idx == IDX_STATUS) begin
            rdata_d = status_in;
        end
`ifdef CHANNEL_EMU_REG_SLVERR_EN
        if (!rd_is_cfg && (rd_idx != IDX_STATUS) && (rd_idx != IDX_CTRL)) begin
            rresp_d = RESP_SLVERR;
        end
`endif
    end

    // Read response register: captured on AR acceptance, held until RREADY.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
            rresp_q  <= RESP_OKAY;
        end else begin
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (S_AXI_RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_REGS; g++) begin : g_cfg_out
            assign cfg_regs[DW*g +: DW] = cfg_q[g];
        end
    endgenerate

    assign S_AXI_BVALID = bvalid_q;
    assign S_AXI_BRESP  = bresp_q;
    assign S_AXI_RVALID = rvalid_q;
    assign S_AXI_RDATA  = rdata_q;
    assign S_AXI_RRESP  = rresp_q;
    assign cfg_wr_stb   = wr_stb_q;
    assign ctrl_pulse   = ctrl_pulse_q;

endmodule
